// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALUControl codes and datapath mux selects.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0110;

  // Selects how alu_decoder derives alu_control
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  localparam logic [1:0] ALUOP_LUI = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;
  localparam logic [1:0] IMM_JU = 2'b11;

  function automatic logic funct3_supported(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUControl decode; fn_illegal flags funct3 values the ALU
// cannot execute, independent of alu_op so DECODE can use it early.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control,
  output logic       fn_illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    fn_illegal  = !funct3_supported(funct3);
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_LUI: alu_control = ALU_LUI;
      default: begin
        // op5 separates R-type from I-type so addi never becomes a subtract
        unique case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences one instruction at a time and drives
// every datapath enable and mux select.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_fn_illegal;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_illegal;
  logic       w_uses_fn;

  alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control),
    .fn_illegal  (w_fn_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= state_t'(RESET_STATE);
    else        r_state <= w_next;
  end

  assign w_uses_fn = (op == OP_RTYPE) || (op == OP_ITYPE);

  always_comb begin
    w_next       = S_FETCH;
    w_alu_op     = ALUOP_ADD;
    w_pc_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    adr_src      = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    imm_src      = IMM_I;
    unique case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        unique case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:  w_next = S_EXECR;
          OP_ITYPE:  w_next = S_EXECI;
          OP_BRANCH: w_next = S_BEQ;
          OP_JAL:    w_next = S_JAL;
          OP_LUI:    w_next = S_LUI;
          default:   w_next = S_FETCH;
        endcase
        // Unsupported ALU functions are rejected here, before any write happens
        if (w_uses_fn && w_fn_illegal) w_next = S_FETCH;
        w_illegal = (w_next == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = op[5] ? IMM_S : IMM_I;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_READDATA;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src      = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        w_alu_op  = ALUOP_FN;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FN;
        w_next    = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_JU;
        w_alu_op  = ALUOP_LUI;
        w_next    = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a    = SRCA_RS1;
        w_alu_op     = ALUOP_SUB;
        w_pc_write   = zero;
        w_instr_done = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // The FETCH enables would otherwise show while reset holds the state there
  assign pc_write   = rst_n & w_pc_write;
  assign ir_write   = rst_n & w_ir_write;
  assign mem_write  = rst_n & w_mem_write;
  assign reg_write  = rst_n & w_reg_write;
  assign instr_done = rst_n & w_instr_done;
  assign illegal    = rst_n & w_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: hand vectors, randomized instructions against an
// instruction-level model, and multi-cycle corner sequences.
module tb_multicycle_controller;

  typedef struct {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [3:0] alu_control;
    logic       instr_done;
    logic       illegal;
  } sampleT;

  // Instruction-level expectation: cycle count, number of cycles each strobe is
  // high, and the ALU code of the third (execute/address) cycle
  typedef struct {
    int         len;
    int         regw;
    int         memw;
    int         pcw;
    int         done;
    int         ill;
    logic [3:0] alu;
  } expT;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    expT        e;
  } vecT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic       instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control;

  int     nVectors = 0;
  int     nMiscompares = 0;
  int     lastLen = 0;
  sampleT smp [1:9];
  vecT    vecs [$];

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic sampleT capture();
    sampleT s;
    s.pc_write    = pc_write;
    s.adr_src     = adr_src;
    s.mem_write   = mem_write;
    s.ir_write    = ir_write;
    s.result_src  = result_src;
    s.alu_src_a   = alu_src_a;
    s.alu_src_b   = alu_src_b;
    s.imm_src     = imm_src;
    s.reg_write   = reg_write;
    s.alu_control = alu_control;
    s.instr_done  = instr_done;
    s.illegal     = illegal;
    return s;
  endfunction

  function automatic expT mk(int len, int regw, int memw, int pcw, int ill, logic [3:0] alu);
    expT e;
    e.len = len; e.regw = regw; e.memw = memw; e.pcw = pcw;
    e.ill = ill; e.done = (ill != 0) ? 0 : 1; e.alu = alu;
    return e;
  endfunction

  // Reference model straight from the ISA behaviour: what each instruction
  // class should cost in cycles and which strobes it should raise
  function automatic expT model(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic       fnOk;
    logic [3:0] fnCode;
    expT        e;
    fnOk   = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    fnCode = (f3 == 3'd2) ? 4'h4 : (f3 == 3'd6) ? 4'h1 : (f3 == 3'd7) ? 4'h0 : 4'h2;
    e = mk(2, 0, 0, 1, 1, 4'h2);
    case (o)
      7'b0000011: e = mk(5, 1, 0, 1, 0, 4'h2);
      7'b0100011: e = mk(4, 0, 1, 1, 0, 4'h2);
      7'b0110011: if (fnOk) e = mk(4, 1, 0, 1, 0, (f3 == 3'd0 && f7) ? 4'h3 : fnCode);
      7'b0010011: if (fnOk) e = mk(4, 1, 0, 1, 0, fnCode);
      7'b1100011: e = mk(3, 0, 0, z ? 2 : 1, 0, 4'h3);
      7'b1101111: e = mk(4, 1, 0, 2, 0, 4'h2);
      7'b0110111: e = mk(4, 1, 0, 1, 0, 4'h6);
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Starts in FETCH (#1 after a rising edge); runs one instruction, recording
  // each cycle until instr_done or illegal, and returns to the next FETCH
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    lastLen = 9;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      smp[c] = capture();
      if (smp[c].instr_done || smp[c].illegal) begin
        lastLen = c;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input expT e);
    int regw, memw, pcw, done, ill, irw, last;
    regw = 0; memw = 0; pcw = 0; done = 0; ill = 0; irw = 0;
    last = (lastLen > 8) ? 8 : lastLen;
    for (int c = 1; c <= last; c++) begin
      regw += int'(smp[c].reg_write);
      memw += int'(smp[c].mem_write);
      pcw  += int'(smp[c].pc_write);
      done += int'(smp[c].instr_done);
      ill  += int'(smp[c].illegal);
      irw  += int'(smp[c].ir_write);
    end
    checkVal({name, " cycles"}, lastLen, e.len);
    checkVal({name, " reg_write cycles"}, regw, e.regw);
    checkVal({name, " mem_write cycles"}, memw, e.memw);
    checkVal({name, " pc_write cycles"}, pcw, e.pcw);
    checkVal({name, " instr_done pulses"}, done, e.done);
    checkVal({name, " illegal pulses"}, ill, e.ill);
    checkVal({name, " ir_write cycles"}, irw, 1);
    checkVal({name, " fetch ir_write"}, int'(smp[1].ir_write), 1);
    if (e.ill == 0 && lastLen >= 3)
      checkVal({name, " alu_control cycle3"}, int'(smp[3].alu_control), int'(e.alu));
  endtask

  initial begin
    vecs.push_back('{"add",    7'b0110011, 3'd0, 1'b0, 1'b0, mk(4, 1, 0, 1, 0, 4'h2)});
    vecs.push_back('{"sub",    7'b0110011, 3'd0, 1'b1, 1'b0, mk(4, 1, 0, 1, 0, 4'h3)});
    vecs.push_back('{"slt",    7'b0110011, 3'd2, 1'b0, 1'b0, mk(4, 1, 0, 1, 0, 4'h4)});
    vecs.push_back('{"and",    7'b0110011, 3'd7, 1'b0, 1'b0, mk(4, 1, 0, 1, 0, 4'h0)});
    vecs.push_back('{"ori",    7'b0010011, 3'd6, 1'b0, 1'b0, mk(4, 1, 0, 1, 0, 4'h1)});
    vecs.push_back('{"addi7",  7'b0010011, 3'd0, 1'b1, 1'b0, mk(4, 1, 0, 1, 0, 4'h2)});
    vecs.push_back('{"lw",     7'b0000011, 3'd2, 1'b0, 1'b0, mk(5, 1, 0, 1, 0, 4'h2)});
    vecs.push_back('{"sw",     7'b0100011, 3'd2, 1'b0, 1'b0, mk(4, 0, 1, 1, 0, 4'h2)});
    vecs.push_back('{"beq_z1", 7'b1100011, 3'd0, 1'b0, 1'b1, mk(3, 0, 0, 2, 0, 4'h3)});
    vecs.push_back('{"beq_z0", 7'b1100011, 3'd0, 1'b0, 1'b0, mk(3, 0, 0, 1, 0, 4'h3)});
    vecs.push_back('{"jal",    7'b1101111, 3'd0, 1'b0, 1'b0, mk(4, 1, 0, 2, 0, 4'h2)});
    vecs.push_back('{"lui",    7'b0110111, 3'd5, 1'b1, 1'b0, mk(4, 1, 0, 1, 0, 4'h6)});
    vecs.push_back('{"ill_op", 7'b1111111, 3'd0, 1'b0, 1'b0, mk(2, 0, 0, 1, 1, 4'h2)});
    vecs.push_back('{"ill_r1", 7'b0110011, 3'd1, 1'b0, 1'b0, mk(2, 0, 0, 1, 1, 4'h2)});
    vecs.push_back('{"ill_i5", 7'b0010011, 3'd5, 1'b0, 1'b0, mk(2, 0, 0, 1, 1, 4'h2)});

    // Reset held low: enables forced off, muxes at their FETCH values
    op = 7'b0110011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("reset enables", int'({pc_write, ir_write, mem_write, reg_write, instr_done, illegal}), 0);
      checkVal("reset alu_src_b", int'(alu_src_b), 2);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(7'b0110011, 3'd0, 1'b0, 1'b0);
    checkVal("post-reset pc_write", int'(smp[1].pc_write), 1);
    checkVal("post-reset decode alu_src_a", int'(smp[2].alu_src_a), 1);
    checkVal("post-reset decode imm_src", int'(smp[2].imm_src), 2);
    checkOutput("post-reset add", model(7'b0110011, 3'd0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      checkOutput(vecs[i].name, vecs[i].e);
    end

    for (int n = 0; n < 60; n++) begin
      logic [6:0] ops [8];
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7, z;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1100011, 7'b1101111, 7'b0110111, 7'b0110011};
      o  = ($urandom_range(0, 9) > 7) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      z  = 1'($urandom);
      applyStimulus(o, f3, f7, z);
      checkOutput($sformatf("rand%0d op=%b f3=%0d", n, o, f3), model(o, f3, f7, z));
    end

    applyStimulus(7'b0000011, 3'd2, 1'b0, 1'b0);
    checkVal("lw memadr alu_src_a", int'(smp[3].alu_src_a), 2);
    checkVal("lw memadr imm_src", int'(smp[3].imm_src), 0);
    checkVal("lw memread adr_src", int'(smp[4].adr_src), 1);
    checkVal("lw memwb result_src", int'(smp[5].result_src), 1);
    checkVal("lw memwb reg_write", int'(smp[5].reg_write), 1);

    applyStimulus(7'b0100011, 3'd2, 1'b0, 1'b0);
    checkVal("sw memadr imm_src", int'(smp[3].imm_src), 1);
    checkVal("sw memwrite mem_write", int'(smp[4].mem_write), 1);
    checkVal("sw memwrite adr_src", int'(smp[4].adr_src), 1);

    applyStimulus(7'b0110111, 3'd0, 1'b0, 1'b0);
    checkVal("lui imm_src", int'(smp[3].imm_src), 3);
    checkVal("lui alu_src_b", int'(smp[3].alu_src_b), 1);
    checkVal("lui aluwb reg_write", int'(smp[4].reg_write), 1);

    applyStimulus(7'b1101111, 3'd0, 1'b0, 1'b0);
    checkVal("jal alu_src_a", int'(smp[3].alu_src_a), 1);
    checkVal("jal alu_src_b", int'(smp[3].alu_src_b), 2);

    // Reset pulled low during MEMREAD of a load: no writeback may follow
    op = 7'b0000011; funct3 = 3'd2;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    checkVal("abort memread adr_src", int'(adr_src), 1);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal("abort reg_write", int'(reg_write), 0);
      checkVal("abort adr_src", int'(adr_src), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(7'b0110011, 3'd0, 1'b1, 1'b0);
    checkOutput("after abort sub", model(7'b0110011, 3'd0, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
